// File: rtl/bus_slave_mem.sv
// rtl/bus_slave_mem.sv - word-addressed req/ack memory slave with wait states and byte lanes
// Optional macro SLV_ERR_EN adds the oSlvErr completion flag.
module bus_slave_mem #(
    parameter int CMD_W   = 1,
    parameter int AW      = 12,
    parameter int DW      = 32,
    parameter int SW      = 4,
    parameter int DEPTH   = 1024,
    parameter int WAIT_ST = 2
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic             iSlvReq,
    input  logic [CMD_W-1:0] iSlvCmd,
    input  logic [AW-1:0]    iSlvAddr,
    input  logic [SW-1:0]    iSlvSel,
    input  logic [DW-1:0]    iSlvWData,
    output logic             oSlvAck,
    output logic [DW-1:0]    oSlvRData
`ifdef SLV_ERR_EN
    ,
    output logic             oSlvErr
`endif
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] WAIT_CNT = 4'(WAIT_ST);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACCESS, ST_ACK} state_t;

    state_t           state, state_nxt;
    logic [3:0]       cnt, cnt_nxt;
    logic             capture;

    logic [CMD_W-1:0] cmd_q;
    logic [AW-1:0]    addr_q;
    logic [SW-1:0]    sel_q;
    logic [DW-1:0]    wdata_q;

    logic [DW-1:0]    mem [DEPTH];

    logic [AW-3:0]    word_idx;
    logic [IW-1:0]    mem_idx;
    logic             in_range;
    logic             is_wr;
    logic             is_rd;
    logic             err_cond;
    logic [DW-1:0]    rd_masked;

    assign word_idx = addr_q[AW-1:2];
    assign mem_idx  = word_idx[IW-1:0];
    assign in_range = (32'(word_idx) < 32'(DEPTH));
    assign is_wr    = (cmd_q == CMD_W'(0));
    assign is_rd    = (cmd_q == CMD_W'(1));
    assign err_cond = !in_range || (addr_q[1:0] != 2'b00) || !(is_wr || is_rd);

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state <= ST_IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Req is only looked at in IDLE; ACK always returns to IDLE even if Req is still held.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        capture   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (iSlvReq) begin
                    capture = 1'b1;
                    if (WAIT_ST > 0) begin
                        state_nxt = ST_WAIT;
                        cnt_nxt   = WAIT_CNT;
                    end else begin
                        state_nxt = ST_ACCESS;
                    end
                end
            end
            ST_WAIT: begin
                cnt_nxt = cnt - 4'd1;
                if (cnt <= 4'd1) begin
                    state_nxt = ST_ACCESS;
                end
            end
            ST_ACCESS: state_nxt = ST_ACK;
            ST_ACK:    state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge iClk) begin
        if (capture) begin
            cmd_q   <= iSlvCmd;
            addr_q  <= iSlvAddr;
            sel_q   <= iSlvSel;
            wdata_q <= iSlvWData;
        end
    end

    // Array is not reset; a reset landing on the ACCESS edge still suppresses the write.
    always_ff @(posedge iClk) begin
        if (!iRst && state == ST_ACCESS && is_wr && in_range) begin
            for (int b = 0; b < SW; b++) begin
                if (sel_q[b]) begin
                    mem[mem_idx][b*8 +: 8] <= wdata_q[b*8 +: 8];
                end
            end
        end
    end

    always_comb begin
        rd_masked = '0;
        for (int b = 0; b < SW; b++) begin
            if (sel_q[b] && is_rd && in_range) begin
                rd_masked[b*8 +: 8] = mem[mem_idx][b*8 +: 8];
            end
        end
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            oSlvAck   <= 1'b0;
            oSlvRData <= '0;
        end else if (state == ST_ACCESS) begin
            oSlvAck   <= 1'b1;
            oSlvRData <= rd_masked;
        end else if (state == ST_ACK) begin
            oSlvAck   <= 1'b0;
        end
    end

`ifdef SLV_ERR_EN
    always_ff @(posedge iClk) begin
        if (iRst) begin
            oSlvErr <= 1'b0;
        end else if (state == ST_ACCESS) begin
            oSlvErr <= err_cond;
        end else begin
            oSlvErr <= 1'b0;
        end
    end
`else
    logic unused_err;
    assign unused_err = err_cond;
`endif

endmodule

// File: tb/tb_bus_slave_mem.sv
// tb/tb_bus_slave_mem.sv - directed bench: default, DEPTH=512 and WAIT_ST=0 instances
module tb_bus_slave_mem;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req  [3];
    logic [0:0]  cmd  [3];
    logic [11:0] addr [3];
    logic [3:0]  sel  [3];
    logic [31:0] wd   [3];
    logic [31:0] rd   [3];
    logic        ack  [3];
    logic        err  [3];
    int          ack_cnt [3];
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    bus_slave_mem #(.DEPTH(1024), .WAIT_ST(2)) u_dut0 (
        .iClk(clk), .iRst(rst), .iSlvReq(req[0]), .iSlvCmd(cmd[0]), .iSlvAddr(addr[0]),
        .iSlvSel(sel[0]), .iSlvWData(wd[0]), .oSlvAck(ack[0]), .oSlvRData(rd[0])
`ifdef SLV_ERR_EN
        , .oSlvErr(err[0])
`endif
    );
    bus_slave_mem #(.DEPTH(512), .WAIT_ST(2)) u_dut1 (
        .iClk(clk), .iRst(rst), .iSlvReq(req[1]), .iSlvCmd(cmd[1]), .iSlvAddr(addr[1]),
        .iSlvSel(sel[1]), .iSlvWData(wd[1]), .oSlvAck(ack[1]), .oSlvRData(rd[1])
`ifdef SLV_ERR_EN
        , .oSlvErr(err[1])
`endif
    );
    bus_slave_mem #(.DEPTH(1024), .WAIT_ST(0)) u_dut2 (
        .iClk(clk), .iRst(rst), .iSlvReq(req[2]), .iSlvCmd(cmd[2]), .iSlvAddr(addr[2]),
        .iSlvSel(sel[2]), .iSlvWData(wd[2]), .oSlvAck(ack[2]), .oSlvRData(rd[2])
`ifdef SLV_ERR_EN
        , .oSlvErr(err[2])
`endif
    );

    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (ack[d] === 1'b1) ack_cnt[d]++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One master transaction; early=1 drops Req and scrambles inputs right after capture.
    task automatic xfer(input int d, input bit rd_n, input logic [11:0] a, input logic [3:0] s,
                        input logic [31:0] w, input bit early,
                        output logic [31:0] r, output int lat, output logic e);
        int edges;
        bit got;
        @(negedge clk);
        req[d] = 1'b1; cmd[d] = rd_n; addr[d] = a; sel[d] = s; wd[d] = w;
        edges = 0; got = 1'b0; lat = -1; r = 'x; e = 1'bx;
        while (!got && edges < 40) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (early) begin
                req[d] = 1'b0; addr[d] = 12'h000; wd[d] = ~w; sel[d] = 4'h0;
            end
            if (ack[d] === 1'b1) begin
                got = 1'b1; lat = edges - 1; r = rd[d]; e = err[d];
            end
        end
        if (!got) chk("ack_timeout", 32'd0, 32'd1);
        @(posedge clk);
        @(negedge clk);
        chk("ack_single", {31'd0, ack[d]}, 32'd0);
        req[d] = 1'b0;
    endtask

    logic [31:0] r;
    logic [31:0] bd [8];
    logic        e;
    int          lat;
    int          base;
    int          t_ack [$];
    int          cyc;

    initial begin
        for (int d = 0; d < 3; d++) begin
            req[d] = 1'b0; cmd[d] = 1'b0; addr[d] = '0; sel[d] = '0; wd[d] = '0;
            ack_cnt[d] = 0;
`ifndef SLV_ERR_EN
            err[d] = 1'b0;
`endif
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk("rst_ack", {31'd0, ack[d]}, 32'd0);
            chk("rst_rdata", rd[d], 32'd0);
`ifdef SLV_ERR_EN
            chk("rst_err", {31'd0, err[d]}, 32'd0);
`endif
        end
        rst = 1'b0;

        xfer(0, 0, 12'h010, 4'hF, 32'hDEADBEEF, 0, r, lat, e);
        chk("wr_lat", 32'(lat), 32'd3);
`ifdef SLV_ERR_EN
        chk("wr_err", {31'd0, e}, 32'd0);
`endif
        xfer(0, 1, 12'h010, 4'hF, 32'h0, 0, r, lat, e);
        chk("rd_lat", 32'(lat), 32'd3);
        chk("rd_data", r, 32'hDEADBEEF);

        xfer(0, 0, 12'h020, 4'hF, 32'h11223344, 0, r, lat, e);
        xfer(0, 0, 12'h020, 4'b0101, 32'hAABBCCDD, 0, r, lat, e);
        xfer(0, 1, 12'h020, 4'hF, 32'h0, 0, r, lat, e);
        chk("lane_full", r, 32'h11BB33DD);
        xfer(0, 1, 12'h020, 4'b0011, 32'h0, 0, r, lat, e);
        chk("lane_mask", r, 32'h000033DD);

        base = ack_cnt[0];
        for (int n = 0; n < 8; n++) begin
            bd[n] = $urandom;
            xfer(0, 0, 12'(12'h100 + 4 * n), 4'hF, bd[n], 0, r, lat, e);
        end
        for (int n = 0; n < 8; n++) begin
            xfer(0, 1, 12'(12'h100 + 4 * n), 4'hF, 32'h0, 0, r, lat, e);
            chk("burst_rd", r, bd[n]);
        end
        chk("burst_acks", 32'(ack_cnt[0] - base), 32'd16);

        xfer(0, 0, 12'hFFC, 4'hF, 32'h5A5A5A5A, 0, r, lat, e);
`ifdef SLV_ERR_EN
        chk("ffc_err", {31'd0, e}, 32'd0);
`endif
        xfer(0, 1, 12'hFFC, 4'hF, 32'h0, 0, r, lat, e);
        chk("ffc_rd", r, 32'h5A5A5A5A);

        xfer(0, 1, 12'h013, 4'hF, 32'h0, 0, r, lat, e);
`ifdef SLV_ERR_EN
        chk("misalign_err", {31'd0, e}, 32'd1);
`else
        chk("misalign_rd", r, 32'hDEADBEEF);
`endif

        xfer(0, 0, 12'h010, 4'h0, 32'h00000000, 0, r, lat, e);
        xfer(0, 1, 12'h010, 4'hF, 32'h0, 0, r, lat, e);
        chk("sel0_wr", r, 32'hDEADBEEF);
        xfer(0, 1, 12'h010, 4'h0, 32'h0, 0, r, lat, e);
        chk("sel0_rd", r, 32'h00000000);

        xfer(0, 0, 12'h080, 4'hF, 32'h0BADC0DE, 1, r, lat, e);
        chk("early_lat", 32'(lat), 32'd3);
        xfer(0, 1, 12'h080, 4'hF, 32'h0, 0, r, lat, e);
        chk("early_rd", r, 32'h0BADC0DE);

        xfer(1, 0, 12'h7FC, 4'hF, 32'h76543210, 0, r, lat, e);
        xfer(1, 0, 12'h800, 4'hF, 32'h12345678, 0, r, lat, e);
        chk("oor_wr_lat", 32'(lat), 32'd3);
`ifdef SLV_ERR_EN
        chk("oor_wr_err", {31'd0, e}, 32'd1);
`endif
        xfer(1, 1, 12'h800, 4'hF, 32'h0, 0, r, lat, e);
        chk("oor_rd", r, 32'h0);
`ifdef SLV_ERR_EN
        chk("oor_rd_err", {31'd0, e}, 32'd1);
`endif
        xfer(1, 1, 12'h7FC, 4'hF, 32'h0, 0, r, lat, e);
        chk("last_word_rd", r, 32'h76543210);

        xfer(0, 0, 12'h040, 4'hF, 32'h0, 0, r, lat, e);
        base = ack_cnt[0];
        @(negedge clk);
        req[0] = 1'b1; cmd[0] = 1'b0; addr[0] = 12'h040; sel[0] = 4'hF; wd[0] = 32'hCAFEF00D;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1; req[0] = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("rstmid_noack", 32'(ack_cnt[0] - base), 32'd0);
        chk("rstmid_rdata", rd[0], 32'h0);
        xfer(0, 1, 12'h040, 4'hF, 32'h0, 0, r, lat, e);
        chk("rstmid_mem", r, 32'h0);

        xfer(2, 0, 12'h030, 4'hF, 32'hFEEDFACE, 0, r, lat, e);
        chk("ws0_wr_lat", 32'(lat), 32'd1);
        xfer(2, 1, 12'h030, 4'hF, 32'h0, 0, r, lat, e);
        chk("ws0_rd_lat", 32'(lat), 32'd1);
        chk("ws0_rd", r, 32'hFEEDFACE);

        @(negedge clk);
        req[2] = 1'b1; cmd[2] = 1'b1; addr[2] = 12'h030; sel[2] = 4'hF;
        cyc = 0;
        repeat (12) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
            if (ack[2] === 1'b1) begin
                t_ack.push_back(cyc);
                chk("b2b_rd", rd[2], 32'hFEEDFACE);
            end
        end
        req[2] = 1'b0;
        chk("b2b_count", 32'(t_ack.size()), 32'd4);
        if (t_ack.size() > 0) chk("b2b_first", 32'(t_ack[0]), 32'd2);
        for (int i = 1; i < t_ack.size(); i++) begin
            chk("b2b_spacing", 32'(t_ack[i] - t_ack[i-1]), 32'd3);
        end
        repeat (4) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog");
    end

endmodule
